dmem_req_ctrl: RTL and testbench
================================

// Module: dmem_req_ctrl
// PURPOSE
// Sequences data-memory accesses issued by the execute stage towards the dcache
// interface: one outstanding request, ready/valid issue, nack retry, exception capture
// and flush/kill. Sits between the exe-stage memory unit and the dmem_* port of
// exe_top. Holds the pipeline lock while an access is in flight.
// PARAMETERS
// ADDR_W       40   request address width (matches addr_t)
// MAX_RETRY    7    nacks tolerated per access before a retry-fail exception
// TIMEOUT      255  cycles in WAIT without a response before a timeout exception
// PORTS
// clk_i              in   1       core clock
// rstn_i             in   1       asynchronous active-low reset
// kill_i             in   1       pipeline flush; abandons the current access
// req_valid_i        in   1       exe presents an access (sampled in IDLE only)
// req_cmd_i          in   5       dcache command (load/store/AMO encoding)
// req_addr_i         in   ADDR_W  virtual address
// req_data_i         in   64      store data
// req_size_i         in   3       op type / size
// req_tag_i          in   8       request tag
// dmem_req_valid_o   out  1       request valid to dcache
// dmem_req_ready_i   in   1       dcache accepts the request
// dmem_req_cmd_o/addr_o/data_o/op_type_o/tag_o  out  5/ADDR_W/64/3/8  latched request
// dmem_req_kill_o    out  1       one-cycle kill of the accepted request
// dmem_resp_valid_i  in   1       response valid
// dmem_resp_replay_i in   1       replayed response (treated as valid)
// dmem_resp_nack_i   in   1       request rejected; must retry
// dmem_resp_data_i   in   64      load data
// dmem_xcpt_ma_ld_i/ma_st_i/pf_ld_i/pf_st_i  in  1 each  misaligned/page-fault flags
// lock_o             out  1       stall exe; high in any state except IDLE/DONE
// done_valid_o       out  1       one-cycle completion pulse
// done_data_o        out  64      load data (0 for stores)
// done_xcpt_o        out  1       access ended in exception
// done_cause_o       out  3       0 none, 1 ma_ld, 2 ma_st, 3 pf_ld, 4 pf_st, 5 retry, 6 timeout
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; retry and timeout counters 0.
// - IDLE: req_valid_i && !kill_i -> latch all req_* fields, go REQ (next cycle valid=1).
// - REQ: dmem_req_valid_o=1 with latched fields held stable until ready; ready -> WAIT,
//   timeout counter cleared.
// - WAIT: priority per cycle: kill_i > xcpt flag > nack > resp_valid|replay > timeout.
//   xcpt flag -> dmem_req_kill_o=1 for that cycle, DONE with cause per table (first
//   listed flag wins). nack -> retry+1; retry==MAX_RETRY -> DONE cause 5, else back
//   to REQ. resp/replay -> DONE, data captured (loads only). Counter==TIMEOUT -> DONE
//   cause 6, kill pulsed.
// - DONE: done_valid_o=1 for exactly one cycle, then IDLE; lock_o=0. Load latency with
//   ready=1 and a response the cycle after acceptance: 3 cycles from req_valid_i.
// - kill_i: in REQ -> valid dropped the same cycle, IDLE. In WAIT -> kill pulsed, DRAIN.
//   In DONE -> done_valid_o suppressed. Kill beats every other event.
// - DRAIN: lock_o=1, responses/nacks for the abandoned access are swallowed; leaves to
//   IDLE on resp/nack or after TIMEOUT cycles; no done pulse.
// - Counters saturate and never wrap; the retry counter clears on each new IDLE->REQ.
// - Stores complete on resp_valid like loads; done_data_o=0.
// STRUCTURE
// - drac_pkg: dmem_ctrl_state_t enum {IDLE,REQ,WAIT,DONE,DRAIN}, dmem_cause_t codes.
// - Single module; the saturating timeout/retry counter is a local always_ff, with
//   no sub-module.
// TESTING
// 1 Load at 0x1000, ready=1, resp next cycle with data 0xDEAD -> done data 0xDEAD,
//   xcpt 0, 3-cycle latency.
// 2 ready low 4 cycles -> valid and fields held stable 4 cycles; done after acceptance.
// 3 nack twice, then resp -> two re-issues, done xcpt 0; 8 nacks -> done cause 5.
// 4 Store, pf_st in WAIT -> kill pulse for 1 cycle, done xcpt 1, cause 4, data 0.
// 5 kill_i in WAIT, then a late resp -> DRAIN swallows it, no done pulse, lock
//   drops, IDLE.
// 6 No response for TIMEOUT cycles -> cause 6; rstn_i low mid-WAIT -> all outputs 0
//   immediately.

Source files
------------

// File: rtl/dmem_req_ctrl_pkg.sv
// Shared types and helpers for the data-memory request sequencer.
package dmem_req_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StDrain
  } dmem_ctrl_state_t;

  typedef enum logic [2:0] {
    CauseNone    = 3'd0,
    CauseMaLd    = 3'd1,
    CauseMaSt    = 3'd2,
    CausePfLd    = 3'd3,
    CausePfSt    = 3'd4,
    CauseRetry   = 3'd5,
    CauseTimeout = 3'd6
  } dmem_cause_t;

  // dcache command encodings used to tell loads from stores
  localparam logic [4:0] CmdXrd = 5'b00000;
  localparam logic [4:0] CmdXwr = 5'b00001;

  // Plain stores return no data; AMOs and loads do.
  function automatic logic cmd_is_store(input logic [4:0] cmd);
    return cmd == CmdXwr;
  endfunction

  // Fixed-priority exception cause: the first asserted flag wins.
  function automatic dmem_cause_t xcpt_cause(input logic ma_ld, input logic ma_st,
                                             input logic pf_ld, input logic pf_st);
    if (ma_ld) return CauseMaLd;
    if (ma_st) return CauseMaSt;
    if (pf_ld) return CausePfLd;
    if (pf_st) return CausePfSt;
    return CauseNone;
  endfunction

endpackage

// File: rtl/dmem_req_ctrl_if.sv
// dcache-side request/response bundle of the data-memory request sequencer.
interface dmem_req_ctrl_if #(
  parameter int unsigned AddrW = 40
);

  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_cmd;
  logic [AddrW-1:0] req_addr;
  logic [63:0]      req_data;
  logic [2:0]       req_op_type;
  logic [7:0]       req_tag;
  logic             req_kill;
  logic             resp_valid;
  logic             resp_replay;
  logic             resp_nack;
  logic [63:0]      resp_data;
  logic             xcpt_ma_ld;
  logic             xcpt_ma_st;
  logic             xcpt_pf_ld;
  logic             xcpt_pf_st;

  // Sequencer side: issues requests, consumes responses.
  modport master (
    output req_valid, req_cmd, req_addr, req_data, req_op_type, req_tag, req_kill,
    input  req_ready, resp_valid, resp_replay, resp_nack, resp_data,
    input  xcpt_ma_ld, xcpt_ma_st, xcpt_pf_ld, xcpt_pf_st
  );

  // dcache side.
  modport slave (
    input  req_valid, req_cmd, req_addr, req_data, req_op_type, req_tag, req_kill,
    output req_ready, resp_valid, resp_replay, resp_nack, resp_data,
    output xcpt_ma_ld, xcpt_ma_st, xcpt_pf_ld, xcpt_pf_st
  );

endinterface

// File: rtl/dmem_req_ctrl.sv
// Data-memory request sequencer: one outstanding dcache access with ready/valid
// issue, nack retry, exception capture, timeout and pipeline-kill handling.
module dmem_req_ctrl
  import dmem_req_ctrl_pkg::*;
#(
  parameter int unsigned AddrW    = 40,
  parameter int unsigned MaxRetry = 7,
  parameter int unsigned Timeout  = 255
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             kill_i,
  input  logic             req_valid_i,
  input  logic [4:0]       req_cmd_i,
  input  logic [AddrW-1:0] req_addr_i,
  input  logic [63:0]      req_data_i,
  input  logic [2:0]       req_size_i,
  input  logic [7:0]       req_tag_i,
  dmem_req_ctrl_if.master  dmem,
  output logic             lock_o,
  output logic             done_valid_o,
  output logic [63:0]      done_data_o,
  output logic             done_xcpt_o,
  output logic [2:0]       done_cause_o
);

  localparam int unsigned RetryW = (MaxRetry > 0) ? $clog2(MaxRetry + 1) : 1;
  localparam int unsigned TmoW   = (Timeout > 0) ? $clog2(Timeout + 1) : 1;

  dmem_ctrl_state_t  state_q;
  logic [4:0]        cmd_q;
  logic [AddrW-1:0]  addr_q;
  logic [63:0]       data_q;
  logic [2:0]        size_q;
  logic [7:0]        tag_q;
  logic [RetryW-1:0] retry_q;
  logic [TmoW-1:0]   tmo_q;
  logic [63:0]       done_data_q;
  logic              done_xcpt_q;
  dmem_cause_t       done_cause_q;

  logic resp_hit;
  logic xcpt_any;
  logic tmo_hit;
  logic retry_max;
  logic issue;

  // Event decode shared by the FSM, the counters and the outputs.
  always_comb begin
    resp_hit  = dmem.resp_valid | dmem.resp_replay;
    xcpt_any  = dmem.xcpt_ma_ld | dmem.xcpt_ma_st | dmem.xcpt_pf_ld | dmem.xcpt_pf_st;
    tmo_hit   = (tmo_q == TmoW'(Timeout));
    retry_max = (retry_q == RetryW'(MaxRetry));
    issue     = (state_q == StIdle) && req_valid_i && !kill_i;
  end

  // Main sequencer: request latch, state and completion record.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      cmd_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      size_q       <= '0;
      tag_q        <= '0;
      done_data_q  <= '0;
      done_xcpt_q  <= 1'b0;
      done_cause_q <= CauseNone;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            cmd_q   <= req_cmd_i;
            addr_q  <= req_addr_i;
            data_q  <= req_data_i;
            size_q  <= req_size_i;
            tag_q   <= req_tag_i;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (kill_i) begin
            state_q <= StIdle;
          end else if (dmem.req_ready) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          // kill > exception > nack > response > timeout
          if (kill_i) begin
            state_q <= StDrain;
          end else if (xcpt_any) begin
            state_q      <= StDone;
            done_data_q  <= '0;
            done_xcpt_q  <= 1'b1;
            done_cause_q <= xcpt_cause(dmem.xcpt_ma_ld, dmem.xcpt_ma_st,
                                       dmem.xcpt_pf_ld, dmem.xcpt_pf_st);
          end else if (dmem.resp_nack) begin
            if (retry_max) begin
              state_q      <= StDone;
              done_data_q  <= '0;
              done_xcpt_q  <= 1'b1;
              done_cause_q <= CauseRetry;
            end else begin
              state_q <= StReq;
            end
          end else if (resp_hit) begin
            state_q      <= StDone;
            done_data_q  <= cmd_is_store(cmd_q) ? 64'd0 : dmem.resp_data;
            done_xcpt_q  <= 1'b0;
            done_cause_q <= CauseNone;
          end else if (tmo_hit) begin
            state_q      <= StDone;
            done_data_q  <= '0;
            done_xcpt_q  <= 1'b1;
            done_cause_q <= CauseTimeout;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        StDrain: begin
          // The abandoned access's answer (or silence) is swallowed here.
          if (resp_hit || dmem.resp_nack || tmo_hit) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Saturating retry and timeout counters.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      retry_q <= '0;
      tmo_q   <= '0;
    end else begin
      if (issue) begin
        retry_q <= '0;
      end else if ((state_q == StWait) && !kill_i && !xcpt_any && dmem.resp_nack &&
                   !retry_max) begin
        retry_q <= retry_q + RetryW'(1);
      end

      // Counts wait cycles in WAIT and DRAIN; restarts on entry to either.
      if (((state_q == StWait) && !kill_i) || (state_q == StDrain)) begin
        if (!tmo_hit) begin
          tmo_q <= tmo_q + TmoW'(1);
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  // Kill gates valid and done combinationally so a flush acts in the same cycle.
  assign dmem.req_valid   = (state_q == StReq) && !kill_i;
  assign dmem.req_cmd     = cmd_q;
  assign dmem.req_addr    = addr_q;
  assign dmem.req_data    = data_q;
  assign dmem.req_op_type = size_q;
  assign dmem.req_tag     = tag_q;
  assign dmem.req_kill    = (state_q == StWait) &&
                            (kill_i || xcpt_any || (tmo_hit && !dmem.resp_nack && !resp_hit));

  assign lock_o       = (state_q == StReq) || (state_q == StWait) || (state_q == StDrain);
  assign done_valid_o = (state_q == StDone) && !kill_i;
  assign done_data_o  = done_data_q;
  assign done_xcpt_o  = done_xcpt_q;
  assign done_cause_o = done_cause_q;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl with a completion scoreboard.
module tb_dmem_req_ctrl;
  import dmem_req_ctrl_pkg::*;

  localparam int unsigned AddrW = 40;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             kill = 1'b0;
  logic             req_valid = 1'b0;
  logic [4:0]       req_cmd = '0;
  logic [AddrW-1:0] req_addr = '0;
  logic [63:0]      req_data = '0;
  logic [2:0]       req_size = '0;
  logic [7:0]       req_tag = '0;
  logic             lock;
  logic             done_valid;
  logic [63:0]      done_data;
  logic             done_xcpt;
  logic [2:0]       done_cause;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int t_issue = 0;

  typedef struct {
    logic [63:0] data;
    logic        xcpt;
    logic [2:0]  cause;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  dmem_req_ctrl_if #(.AddrW(AddrW)) dmem ();

  dmem_req_ctrl #(
    .AddrW   (AddrW),
    .MaxRetry(7),
    .Timeout (255)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .kill_i      (kill),
    .req_valid_i (req_valid),
    .req_cmd_i   (req_cmd),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_size_i  (req_size),
    .req_tag_i   (req_tag),
    .dmem        (dmem),
    .lock_o      (lock),
    .done_valid_o(done_valid),
    .done_data_o (done_data),
    .done_xcpt_o (done_xcpt),
    .done_cause_o(done_cause)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the next scoreboard entry.
  always @(negedge clk) begin
    if (rstn && done_valid) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(done_valid), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_data", done_data, mon_e.data);
        check("done_xcpt", 64'(done_xcpt), 64'(mon_e.xcpt));
        check("done_cause", 64'(done_cause), 64'(mon_e.cause));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic x, input dmem_cause_t c);
    exp_t e;
    e.data  = d;
    e.xcpt  = x;
    e.cause = c;
    sb_q.push_back(e);
  endtask

  // Presents one request for a single cycle; returns in the first REQ cycle.
  task automatic issue(input logic [4:0] cmd, input logic [AddrW-1:0] addr,
                       input logic [63:0] data, input logic [7:0] tag);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    req_data  = data;
    req_size  = 3'd3;
    req_tag   = tag;
    t_issue   = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic [63:0] d);
    dmem.resp_valid = 1'b1;
    dmem.resp_data  = d;
    step();
    dmem.resp_valid = 1'b0;
    dmem.resp_data  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int n;
    int kn;
    logic seen;

    dmem.req_ready   = 1'b0;
    dmem.resp_valid  = 1'b0;
    dmem.resp_replay = 1'b0;
    dmem.resp_nack   = 1'b0;
    dmem.resp_data   = '0;
    dmem.xcpt_ma_ld  = 1'b0;
    dmem.xcpt_ma_st  = 1'b0;
    dmem.xcpt_pf_ld  = 1'b0;
    dmem.xcpt_pf_st  = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_lock", 64'(lock), 64'd0);
    check("rst_done_valid", 64'(done_valid), 64'd0);
    check("rst_req_valid", 64'(dmem.req_valid), 64'd0);
    check("rst_req_kill", 64'(dmem.req_kill), 64'd0);
    check("rst_done_cause", 64'(done_cause), 64'd0);
    step();
    rstn = 1'b1;
    step();

    // 1: load, immediate accept, response next cycle
    dmem.req_ready = 1'b1;
    push(64'hDEAD, 1'b0, CauseNone);
    issue(CmdXrd, 40'h1000, 64'd0, 8'h11);
    @(negedge clk);
    check("t1_req_valid", 64'(dmem.req_valid), 64'd1);
    check("t1_req_addr", 64'(dmem.req_addr), 64'h1000);
    check("t1_lock", 64'(lock), 64'd1);
    step();
    respond(64'hDEAD);
    @(negedge clk);
    check("t1_done_pulse", 64'(done_valid), 64'd1);
    check("t1_done_lock", 64'(lock), 64'd0);
    step();
    check("t1_latency", 64'(last_done_cyc - t_issue), 64'd3);
    @(negedge clk);
    check("t1_pulse_once", 64'(done_valid), 64'd0);

    // 2: ready low for 4 cycles, request held stable
    dmem.req_ready = 1'b0;
    push(64'h1234, 1'b0, CauseNone);
    issue(CmdXrd, 40'h20_0000_2040, 64'd0, 8'h22);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 64'(dmem.req_valid), 64'd1);
      check("t2_hold_addr", 64'(dmem.req_addr), 64'h20_0000_2040);
      check("t2_hold_tag", 64'(dmem.req_tag), 64'h22);
      step();
    end
    dmem.req_ready = 1'b1;
    step();
    respond(64'h1234);
    @(negedge clk);
    check("t2_done", 64'(done_valid), 64'd1);
    step();

    // 3a: two nacks, then a response
    push(64'h0BEE, 1'b0, CauseNone);
    issue(CmdXrd, 40'h3000, 64'd0, 8'h33);
    step();
    for (int i = 0; i < 2; i++) begin
      dmem.resp_nack = 1'b1;
      step();
      dmem.resp_nack = 1'b0;
      @(negedge clk);
      check("t3_reissue", 64'(dmem.req_valid), 64'd1);
      step();
    end
    respond(64'h0BEE);
    @(negedge clk);
    check("t3_done", 64'(done_valid), 64'd1);
    step();

    // 3b: eight nacks exhaust the retry budget
    push(64'd0, 1'b1, CauseRetry);
    issue(CmdXrd, 40'h3008, 64'd0, 8'h34);
    step();
    for (int i = 0; i < 8; i++) begin
      dmem.resp_nack = 1'b1;
      step();
      dmem.resp_nack = 1'b0;
      if (i < 7) step();
    end
    @(negedge clk);
    check("t3_retry_done", 64'(done_valid), 64'd1);
    step();

    // 4: store with page fault in WAIT
    push(64'd0, 1'b1, CausePfSt);
    issue(CmdXwr, 40'h4008, 64'hCAFE, 8'h44);
    step();
    dmem.xcpt_pf_st = 1'b1;
    @(negedge clk);
    check("t4_kill", 64'(dmem.req_kill), 64'd1);
    step();
    dmem.xcpt_pf_st = 1'b0;
    @(negedge clk);
    check("t4_kill_one_cycle", 64'(dmem.req_kill), 64'd0);
    check("t4_done", 64'(done_valid), 64'd1);
    step();

    // 4b: store completes on response with zero data
    push(64'd0, 1'b0, CauseNone);
    issue(CmdXwr, 40'h4010, 64'h55, 8'h45);
    step();
    respond(64'hFFFF_FFFF);
    step();

    // 4c: ma_st outranks pf_ld, and an exception outranks a nack
    push(64'd0, 1'b1, CauseMaSt);
    issue(CmdXrd, 40'h4011, 64'd0, 8'h46);
    step();
    dmem.xcpt_ma_st = 1'b1;
    dmem.xcpt_pf_ld = 1'b1;
    dmem.resp_nack  = 1'b1;
    step();
    dmem.xcpt_ma_st = 1'b0;
    dmem.xcpt_pf_ld = 1'b0;
    dmem.resp_nack  = 1'b0;
    step();

    // 5: kill in WAIT, late response swallowed by DRAIN
    n0 = done_cnt;
    issue(CmdXrd, 40'h5000, 64'd0, 8'h55);
    step();
    kill = 1'b1;
    @(negedge clk);
    check("t5_kill_wait", 64'(dmem.req_kill), 64'd1);
    step();
    kill = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_drain_lock", 64'(lock), 64'd1);
      step();
    end
    respond(64'h5555);
    @(negedge clk);
    check("t5_lock_drop", 64'(lock), 64'd0);
    check("t5_no_done", 64'(done_cnt), 64'(n0));
    step();

    // 5b: kill in REQ drops valid the same cycle
    issue(CmdXrd, 40'h5100, 64'd0, 8'h56);
    kill = 1'b1;
    @(negedge clk);
    check("t5_req_kill_valid", 64'(dmem.req_valid), 64'd0);
    step();
    kill = 1'b0;
    @(negedge clk);
    check("t5_req_kill_idle", 64'(lock), 64'd0);
    step();

    // 5c: kill in DONE suppresses the pulse
    issue(CmdXrd, 40'h5200, 64'd0, 8'h57);
    step();
    respond(64'h77);
    kill = 1'b1;
    @(negedge clk);
    check("t5_done_suppressed", 64'(done_valid), 64'd0);
    step();
    kill = 1'b0;
    check("t5_no_done_count", 64'(done_cnt), 64'(n0));

    // 6: timeout after 256 silent WAIT cycles (counter reaches 255)
    push(64'd0, 1'b1, CauseTimeout);
    issue(CmdXrd, 40'h6000, 64'd0, 8'h66);
    step();
    n = 0;
    kn = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      if (dmem.req_kill) kn++;
      if (done_valid) begin
        seen = 1'b1;
      end else begin
        n++;
        step();
      end
    end
    check("t6_timeout_seen", 64'(seen), 64'd1);
    check("t6_wait_cycles", 64'(n), 64'd256);
    check("t6_kill_count", 64'(kn), 64'd1);
    step();

    // 6b: asynchronous reset mid-WAIT clears outputs immediately
    issue(CmdXrd, 40'h7000, 64'd0, 8'h77);
    step();
    dmem.xcpt_ma_ld = 1'b1;
    #1;
    check("t6_pre_rst_kill", 64'(dmem.req_kill), 64'd1);
    rstn = 1'b0;
    #1;
    check("t6_rst_lock", 64'(lock), 64'd0);
    check("t6_rst_kill", 64'(dmem.req_kill), 64'd0);
    check("t6_rst_addr", 64'(dmem.req_addr), 64'd0);
    check("t6_rst_cause", 64'(done_cause), 64'd0);
    check("t6_rst_xcpt", 64'(done_xcpt), 64'd0);
    dmem.xcpt_ma_ld = 1'b0;
    step();
    rstn = 1'b1;
    step();

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
